matrix_load_sequencer: RTL and testbench

- Parametrised instruction sequencer that generates and issues the matrix-store instruction stream for the matrix coprocessor.
- Replaces hand-instantiated per-cell store instructions.
- Walks every cell of each selected matrix, applies a sparsity pattern and a data source, then issues one store instruction per selected cell over a valid/ready handshake.
- Sits between the control/switch logic and the coprocessor instruction input.

---
 rtl/matrix_load_sequencer.sv | 98 +++++++++
 tb/tb_matrix_load_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_load_sequencer.sv
// matrix_load_sequencer: walks selected matrix cells through a sparsity pattern and issues one store instruction per selected cell
module matrix_load_sequencer #(
  parameter int DATA_W = 8,
  parameter int MAT_DIM = 5,
  parameter int IDX_W = 3,
  parameter int NUM_MAT = 2,
  parameter logic [1:0] OP_CLASS = 2'b10,
  parameter logic [3:0] OPCODE_ST = 4'b0010,
  parameter int INSTR_W = 2 + DATA_W + 2 + 2 * IDX_W + 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               data_inc,
  input  logic [DATA_W-1:0]  fill_value,
  input  logic [NUM_MAT-1:0] mat_mask,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               done,
  output logic [15:0]        issued_cnt
);
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;
  localparam logic [IDX_W-1:0] last_idx = IDX_W'(MAT_DIM - 1);
  state_t state, state_nxt;
  logic [1:0] mode_q, m, m_nxt, m_first;
  logic inc_q, more, sel, last, accept, advance;
  logic [NUM_MAT-1:0] mask_q;
  logic [DATA_W-1:0] data;
  logic [IDX_W-1:0] r, c;
  assign instr_valid = state == ISSUE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    m_first = '0;
    m_nxt = m;
    more = 1'b0;
    // descending scan so the lowest qualifying matrix id wins
    for (int i = NUM_MAT - 1; i >= 0; i--) begin
      if (mat_mask[i]) m_first = 2'(i);
      if (mask_q[i] && 2'(i) > m) begin
        m_nxt = 2'(i);
        more = 1'b1;
      end
    end
    sel = mode_q == 2'b00 ? 1'b1 :
          mode_q == 2'b01 ? ~(r[0] ^ c[0]) :
          mode_q == 2'b10 ? r == c : c >= r;
    last = r == last_idx && c == last_idx && !more;
    accept = state == ISSUE && instr_ready;
    advance = (state == SCAN && !sel) || accept;
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = |mat_mask ? SCAN : DONE;
      SCAN: state_nxt = sel ? ISSUE : last ? DONE : SCAN;
      ISSUE: if (instr_ready) state_nxt = last ? DONE : SCAN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mode_q <= '0;
      inc_q <= 1'b0;
      mask_q <= '0;
      data <= '0;
      m <= '0;
      r <= '0;
      c <= '0;
      instr <= '0;
      issued_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        mode_q <= mode;
        inc_q <= data_inc;
        mask_q <= mat_mask;
        data <= fill_value;
        m <= m_first;
        r <= '0;
        c <= '0;
        issued_cnt <= '0;
      end
      if (state == SCAN && sel) instr <= {OP_CLASS, data, m, r, c, OPCODE_ST};
      if (accept) begin
        issued_cnt <= issued_cnt + 16'd1;
        if (inc_q) data <= data + 1'b1;
      end
      if (advance) begin
        c <= c == last_idx ? '0 : c + 1'b1;
        if (c == last_idx) r <= r == last_idx ? '0 : r + 1'b1;
        if (c == last_idx && r == last_idx) m <= m_nxt;
      end
    end
  end
endmodule

// File: tb/tb_matrix_load_sequencer.sv
// tb_matrix_load_sequencer: randomized and directed checks against a cell-walking reference model
module tb_matrix_load_sequencer;
  logic clk = 0, rst_n = 0, start = 0, data_inc = 0, instr_ready = 0;
  logic [1:0] mode = 0, mat_mask = 0;
  logic [7:0] fill_value = 0;
  logic [21:0] instr;
  logic instr_valid, busy, done;
  logic [15:0] issued_cnt;
  int compared = 0, mismatched = 0;
  logic [21:0] got[$], exp_q[$];
  int dones, first_done, unstable, valid_seen;
  logic [21:0] stall_instr;

  matrix_load_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .data_inc(data_inc),
    .fill_value(fill_value), .mat_mask(mat_mask), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .done(done), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic build_exp(input logic [1:0] md, input logic inc, input logic [7:0] fill, input logic [1:0] mask);
    logic [7:0] d = fill;
    exp_q.delete();
    for (int mi = 0; mi < 2; mi++)
      if (mask[mi])
        for (int ri = 0; ri < 5; ri++)
          for (int ci = 0; ci < 5; ci++)
            if (md == 0 || (md == 1 && (ri + ci) % 2 == 0) || (md == 2 && ri == ci) || (md == 3 && ci >= ri)) begin
              exp_q.push_back({2'b10, d, 2'(mi), 3'(ri), 3'(ci), 4'b0010});
              if (inc) d = d + 8'd1;
            end
  endtask

  task automatic run(input logic [1:0] md, input logic inc, input logic [7:0] fill, input logic [1:0] mask,
                     input int stall_len, input bit rnd, input int restart_at);
    logic [21:0] prev = '0;
    bit hold = 0;
    int stalled = 0, after = 0;
    got.delete();
    dones = 0; first_done = 0; unstable = 0; valid_seen = 0; stall_instr = '0;
    build_exp(md, inc, fill, mask);
    @(negedge clk);
    mode = md; data_inc = inc; fill_value = fill; mat_mask = mask; start = 1; instr_ready = 1;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      mode = 2'($urandom); data_inc = 1'($urandom); fill_value = 8'($urandom); mat_mask = 2'($urandom);
      if (hold && (instr !== prev || !instr_valid)) unstable++;
      if (instr_valid) valid_seen++;
      if (done) begin
        dones++;
        if (first_done == 0) first_done = cyc;
      end
      instr_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (instr_valid && got.size() == 2 && stalled < stall_len) begin
        instr_ready = 0;
        stalled++;
        if (stalled == 1) stall_instr = instr;
      end
      if (instr_valid && instr_ready) got.push_back(instr);
      hold = instr_valid && !instr_ready;
      prev = instr;
      if (dones > 0 && ++after > 3) break;
    end
    start = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    compared++;
    if ({instr, instr_valid, busy, done, issued_cnt} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs got instr=%h v=%b busy=%b done=%b cnt=%0d exp all 0", instr, instr_valid, busy, done, issued_cnt);
    end
    rst_n = 1;
  endtask

  task automatic test_checkerboard;
    logic [21:0] spot[4] = '{22'b10_11111111_00_000_000_0010, 22'b10_11111111_00_000_010_0010,
                             22'b10_11111111_01_000_000_0010, 22'b10_11111111_01_100_100_0010};
    int idx[4] = '{0, 1, 13, 25};
    run(2'b01, 0, 8'hFF, 2'b11, 0, 0, 0);
    compared++;
    if (got.size() != 26) begin mismatched++; $display("FAIL cb_count got %0d exp 26", got.size()); end
    foreach (spot[k]) begin
      compared++;
      if (got.size() <= idx[k] || got[idx[k]] !== spot[k]) begin
        mismatched++;
        $display("FAIL cb_spot[%0d] got %b exp %b", idx[k], got.size() > idx[k] ? got[idx[k]] : 22'hx, spot[k]);
      end
    end
    foreach (exp_q[i]) begin
      compared++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin mismatched++; $display("FAIL cb_seq[%0d] got %h exp %h", i, i < got.size() ? got[i] : 22'hx, exp_q[i]); end
    end
    compared++;
    if (dones != 1 || issued_cnt !== 16'd26) begin mismatched++; $display("FAIL cb_done got dones=%0d cnt=%0d exp 1/26", dones, issued_cnt); end
  endtask

  task automatic test_backpressure;
    run(2'b01, 0, 8'hFF, 2'b11, 5, 0, 0);
    compared++;
    if (stall_instr !== 22'b10_11111111_00_000_100_0010) begin mismatched++; $display("FAIL bp_stall_instr got %b exp %b", stall_instr, 22'b10_11111111_00_000_100_0010); end
    compared++;
    if (unstable != 0) begin mismatched++; $display("FAIL bp_stable got %0d unstable cycles exp 0", unstable); end
    compared++;
    if (got.size() != 26 || issued_cnt !== 16'd26) begin mismatched++; $display("FAIL bp_count got %0d/%0d exp 26", got.size(), issued_cnt); end
    foreach (exp_q[i]) begin
      compared++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin mismatched++; $display("FAIL bp_seq[%0d] got %h exp %h", i, i < got.size() ? got[i] : 22'hx, exp_q[i]); end
    end
  endtask

  task automatic test_inc_wrap;
    logic [7:0] wd[5] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    run(2'b10, 1, 8'hFE, 2'b01, 0, 0, 0);
    compared++;
    if (got.size() != 5) begin mismatched++; $display("FAIL wrap_count got %0d exp 5", got.size()); end
    foreach (wd[i]) begin
      compared++;
      if (i >= got.size() || got[i][19:12] !== wd[i] || got[i][9:7] !== 3'(i) || got[i][6:4] !== 3'(i)) begin
        mismatched++;
        $display("FAIL wrap[%0d] got %h exp data %h at (%0d,%0d)", i, i < got.size() ? got[i] : 22'hx, wd[i], i, i);
      end
    end
  endtask

  task automatic test_empty;
    run(2'b00, 0, 8'h11, 2'b00, 0, 0, 0);
    compared++;
    if (valid_seen != 0) begin mismatched++; $display("FAIL empty_valid got %0d valid cycles exp 0", valid_seen); end
    compared++;
    if (dones != 1 || first_done < 1 || first_done > 2) begin mismatched++; $display("FAIL empty_done got %0d pulses at cycle %0d exp 1 within 2", dones, first_done); end
    compared++;
    if (issued_cnt !== 16'd0) begin mismatched++; $display("FAIL empty_cnt got %0d exp 0", issued_cnt); end
  endtask

  task automatic test_start_busy;
    run(2'b00, 0, 8'h5A, 2'b10, 0, 0, 10);
    compared++;
    if (got.size() != 25 || dones != 1) begin mismatched++; $display("FAIL busy_start got %0d instrs %0d dones exp 25/1", got.size(), dones); end
    foreach (exp_q[i]) begin
      compared++;
      if (i >= got.size() || got[i] !== exp_q[i] || got[i][11:10] !== 2'b01) begin mismatched++; $display("FAIL busy_seq[%0d] got %h exp %h", i, i < got.size() ? got[i] : 22'hx, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int n = 0, late_done = 0, late_valid = 0;
    @(negedge clk);
    mode = 2'b00; data_inc = 0; fill_value = 8'h33; mat_mask = 2'b10; start = 1; instr_ready = 1;
    for (int cyc = 0; cyc < 200 && n < 7; cyc++) begin
      @(negedge clk);
      start = 0;
      if (instr_valid && instr_ready) n++;
    end
    @(negedge clk);
    compared++;
    if (issued_cnt !== 16'd7) begin mismatched++; $display("FAIL rstmid_pre_cnt got %0d exp 7", issued_cnt); end
    rst_n = 0;
    @(negedge clk);
    compared++;
    if (instr_valid !== 0 || busy !== 0 || issued_cnt !== 0 || done !== 0) begin
      mismatched++;
      $display("FAIL rstmid_outputs got v=%b busy=%b cnt=%0d done=%b exp all 0", instr_valid, busy, issued_cnt, done);
    end
    rst_n = 1;
    repeat (20) begin
      @(negedge clk);
      if (done) late_done++;
      if (instr_valid) late_valid++;
    end
    compared++;
    if (late_done != 0 || late_valid != 0) begin mismatched++; $display("FAIL rstmid_after got done=%0d valid=%0d exp 0/0", late_done, late_valid); end
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      logic [1:0] md = 2'($urandom), mk = 2'($urandom);
      logic inc = 1'($urandom);
      logic [7:0] fl = 8'($urandom);
      run(md, inc, fl, mk, 0, 1, 0);
      compared++;
      if (got.size() != exp_q.size() || issued_cnt !== 16'(exp_q.size()) || dones != 1 || unstable != 0) begin
        mismatched++;
        $display("FAIL rand%0d_run got n=%0d cnt=%0d dones=%0d unstable=%0d exp n=%0d dones=1", t, got.size(), issued_cnt, dones, unstable, exp_q.size());
      end
      foreach (exp_q[i]) begin
        compared++;
        if (i >= got.size() || got[i] !== exp_q[i]) begin mismatched++; $display("FAIL rand%0d_seq[%0d] got %h exp %h", t, i, i < got.size() ? got[i] : 22'hx, exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_checkerboard;
    test_backpressure;
    test_inc_wrap;
    test_empty;
    test_start_busy;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
